// File: rtl/uart_rx_os_if.sv
// Read-side handshake bundle of the oversampling UART receiver.
// The receiver is the master (presents the FIFO head); the consumer is the slave.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_parity_err;
  logic                 rd_frame_err;
  logic                 rd_valid;
  logic                 rd_ready;

  modport master (
    output rd_data, rd_parity_err, rd_frame_err, rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data, rd_parity_err, rd_frame_err, rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop input synchroniser, tick generator,
// majority-vote bit sampling, runtime frame format, break/overrun detection
// and a first-word-fall-through receive FIFO with per-entry error tags.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_divisor,
  input  logic [1:0]                    stop_bits,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          rx,
  input  logic                          clr_overrun,
  uart_rx_os_if.master                  rd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          break_det
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int ENT_W = DATA_BITS + 2;

  localparam logic [SC_W-1:0]  SC_LO    = SC_W'(OVERSAMPLE/2 - 1);
  localparam logic [SC_W-1:0]  SC_MID   = SC_W'(OVERSAMPLE/2);
  localparam logic [SC_W-1:0]  SC_HI    = SC_W'(OVERSAMPLE/2 + 1);
  localparam logic [SC_W-1:0]  SC_END   = SC_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state;
  logic                 rx_meta, rx_sync;
  logic [DIV_W-1:0]     div_cnt, div_last;
  logic                 tick;
  logic [SC_W-1:0]      sc;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 s_lo, s_mid, vote;
  logic                 par_bit, perr, ferr_acc, stop0_zero, wait_high;
  logic                 cfg_two_stop, cfg_par_en, cfg_odd;
  logic                 stop_last, first_stop_zero, is_break, commit_now;
  logic [ENT_W-1:0]     wr_word, head;

  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 rd_fire, full, wr_en, drop;

  // Bring the asynchronous serial line into the clk domain; idle level is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Oversample tick: wrap detection uses >= so a live divisor decrease cannot strand the counter.
  always_comb begin
    div_last = (baud_divisor == '0) ? '0 : baud_divisor - 1'b1;
    tick     = (div_cnt >= div_last);
  end

  // Free-running tick counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Vote, commit and break qualification for the current tick.
  always_comb begin
    vote            = (s_lo & s_mid) | (s_lo & rx_sync) | (s_mid & rx_sync);
    stop_last       = !cfg_two_stop || stop_idx;
    first_stop_zero = stop_idx ? stop0_zero : !vote;
    is_break        = (shreg == '0) && (!cfg_par_en || !par_bit) && first_stop_zero;
    commit_now      = tick && (state == ST_STOP) && (sc == SC_HI) && stop_last;
    wr_word         = {perr, ferr_acc | !vote, shreg};
  end

  // Frame FSM: the commit happens on the last stop bit's final vote sample, mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sc           <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      s_lo         <= 1'b1;
      s_mid        <= 1'b1;
      par_bit      <= 1'b0;
      perr         <= 1'b0;
      ferr_acc     <= 1'b0;
      stop0_zero   <= 1'b0;
      wait_high    <= 1'b0;
      cfg_two_stop <= 1'b0;
      cfg_par_en   <= 1'b0;
      cfg_odd      <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      break_det <= 1'b0;
      if (tick) begin
        if (state != ST_IDLE) begin
          sc <= (sc == SC_END) ? '0 : sc + 1'b1;
          if (sc == SC_LO)  s_lo  <= rx_sync;
          if (sc == SC_MID) s_mid <= rx_sync;
        end
        case (state)
          ST_IDLE: begin
            if (wait_high) begin
              if (rx_sync) wait_high <= 1'b0;
            end else if (!rx_sync) begin
              state        <= ST_START;
              sc           <= '0;
              bit_idx      <= '0;
              stop_idx     <= 1'b0;
              perr         <= 1'b0;
              ferr_acc     <= 1'b0;
              cfg_two_stop <= (stop_bits == 2'd2);
              cfg_par_en   <= parity_en;
              cfg_odd      <= parity_odd;
            end
          end
          ST_START: begin
            if (sc == SC_HI && vote)  state <= ST_IDLE;
            else if (sc == SC_END)    state <= ST_DATA;
          end
          ST_DATA: begin
            if (sc == SC_HI) shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (sc == SC_END) begin
              if (bit_idx == BIT_LAST) state <= cfg_par_en ? ST_PARITY : ST_STOP;
              else                     bit_idx <= bit_idx + 1'b1;
            end
          end
          ST_PARITY: begin
            if (sc == SC_HI) begin
              par_bit <= vote;
              perr    <= vote ^ (^shreg) ^ cfg_odd;
            end else if (sc == SC_END) begin
              state <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (sc == SC_HI) begin
              if (!vote)          ferr_acc   <= 1'b1;
              if (!stop_idx)      stop0_zero <= !vote;
              if (stop_last) begin
                state     <= ST_IDLE;
                break_det <= is_break;
                wait_high <= is_break;
              end
            end else if (sc == SC_END) begin
              stop_idx <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // FIFO control: a write into a full FIFO is only accepted alongside a read.
  always_comb begin
    rd_fire = rd.rd_valid && rd.rd_ready;
    full    = (fifo_count == CNT_FULL);
    wr_en   = commit_now && (!full || rd_fire);
    drop    = commit_now && full && !rd_fire;
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  // Pointers, occupancy and sticky overrun (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_fire})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  // First-word fall-through head; outputs forced to zero while empty.
  always_comb begin
    head             = mem[rd_ptr];
    rd.rd_valid      = (fifo_count != '0);
    rd.rd_data       = rd.rd_valid ? head[DATA_BITS-1:0] : '0;
    rd.rd_frame_err  = rd.rd_valid & head[DATA_BITS];
    rd.rd_parity_err = rd.rd_valid & head[DATA_BITS+1];
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8-bit build for most frames and a
// 9-bit, two-stop, odd-parity build for the format case.
module tb_uart_rx_os;
  localparam int DIV      = 2;
  localparam int OS       = 16;
  localparam int BIT_CLKS = DIV * OS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] baud_divisor = 16'(DIV);
  logic [1:0]  stop_bits = 2'd1;
  logic        parity_en = 1'b1, parity_odd = 1'b0;
  logic        rx = 1'b1, rx9 = 1'b1, clr_overrun = 1'b0;
  logic [1:0]  stop_bits9 = 2'd2;
  logic        parity_en9 = 1'b1, parity_odd9 = 1'b1, clr_overrun9 = 1'b0;
  logic [4:0]  fifo_count, fifo_count9;
  logic        overrun, break_det, overrun9, break_det9;

  uart_rx_os_if #(.DATA_BITS(8)) rd8 ();
  uart_rx_os_if #(.DATA_BITS(9)) rd9 ();

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS), .FIFO_DEPTH(16), .DIV_W(16)) dut8 (
    .clk(clk), .rst(rst), .baud_divisor(baud_divisor), .stop_bits(stop_bits),
    .parity_en(parity_en), .parity_odd(parity_odd), .rx(rx), .clr_overrun(clr_overrun),
    .rd(rd8), .fifo_count(fifo_count), .overrun(overrun), .break_det(break_det)
  );

  uart_rx_os #(.DATA_BITS(9), .OVERSAMPLE(OS), .FIFO_DEPTH(16), .DIV_W(16)) dut9 (
    .clk(clk), .rst(rst), .baud_divisor(baud_divisor), .stop_bits(stop_bits9),
    .parity_en(parity_en9), .parity_odd(parity_odd9), .rx(rx9), .clr_overrun(clr_overrun9),
    .rd(rd9), .fifo_count(fifo_count9), .overrun(overrun9), .break_det(break_det9)
  );

  int n_vec = 0, n_miss = 0, brk_cnt = 0;
  logic [10:0] exp8_q[$];
  logic [10:0] exp9_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit build: pop and compare on every read transfer.
  always @(negedge clk) begin
    if (!rst && rd8.rd_valid && rd8.rd_ready) begin
      if (exp8_q.size() == 0) begin
        check("rd8_unexpected", 32'({rd8.rd_parity_err, rd8.rd_frame_err, 1'b0, rd8.rd_data}), 32'h7ff);
      end else begin
        check("rd8_entry", 32'({rd8.rd_parity_err, rd8.rd_frame_err, 1'b0, rd8.rd_data}),
              32'(exp8_q.pop_front()));
      end
    end
  end

  // Monitor for the 9-bit build.
  always @(negedge clk) begin
    if (!rst && rd9.rd_valid && rd9.rd_ready) begin
      if (exp9_q.size() == 0) begin
        check("rd9_unexpected", 32'({rd9.rd_parity_err, rd9.rd_frame_err, rd9.rd_data}), 32'h7ff);
      end else begin
        check("rd9_entry", 32'({rd9.rd_parity_err, rd9.rd_frame_err, rd9.rd_data}),
              32'(exp9_q.pop_front()));
      end
    end
  end

  always @(negedge clk) if (break_det) brk_cnt++;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line(input bit sel, input logic v, input int unsigned n);
    if (sel) rx9 = v;
    else     rx  = v;
    cyc(n);
  endtask

  // One frame: gbit selects a data bit carrying a one-tick inverted glitch at mid-bit (-1 = none).
  task automatic send_frame(input bit sel, input logic [8:0] d, input int nb, input logic pen,
                            input logic podd, input logic pflip, input logic s1, input logic s2,
                            input int nstop, input int gbit, input logic idle_v);
    logic p;
    p = podd ^ pflip;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    line(sel, 1'b0, BIT_CLKS);
    for (int i = 0; i < nb; i++) begin
      if (i == gbit) begin
        line(sel, d[i], BIT_CLKS/2);
        line(sel, !d[i], DIV);
        line(sel, d[i], BIT_CLKS/2 - DIV);
      end else begin
        line(sel, d[i], BIT_CLKS);
      end
    end
    if (pen) line(sel, p, BIT_CLKS);
    line(sel, s1, BIT_CLKS);
    if (nstop == 2) line(sel, s2, BIT_CLKS);
    line(sel, idle_v, BIT_CLKS);
  endtask

  task automatic wait_commit(input string name);
    int k;
    k = 0;
    while (!dut8.commit_now && k < 20*BIT_CLKS) begin
      cyc(1);
      k++;
    end
    if (k >= 20*BIT_CLKS) check(name, 32'd0, 32'd1);
  endtask

  task automatic drain8(input string name);
    int k;
    k = 0;
    while (exp8_q.size() != 0 && k < 40*BIT_CLKS) begin
      cyc(1);
      k++;
    end
    check(name, 32'(exp8_q.size()), 32'd0);
  endtask

  initial begin
    int b0;
    rd8.rd_ready = 1'b1;
    rd9.rd_ready = 1'b1;
    cyc(3);
    check("rst_rd_valid", 32'(rd8.rd_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_break", 32'(break_det), 32'd0);
    check("rst_rd_data", 32'(rd8.rd_data), 32'd0);
    rst = 1'b0;
    cyc(BIT_CLKS);

    // Basic 0xA5, even parity, one stop; rd_valid one cycle after commit.
    exp8_q.push_back({2'b00, 9'h0A5});
    fork
      send_frame(1'b0, 9'h0A5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
      begin
        wait_commit("basic_commit_timeout");
        check("basic_valid_at_commit", 32'(rd8.rd_valid), 32'd0);
        cyc(1);
        check("basic_valid_after", 32'(rd8.rd_valid), 32'd1);
        check("basic_count", 32'(fifo_count), 32'd1);
      end
    join
    drain8("basic_drain");

    // Parity error and framing error tagging.
    exp8_q.push_back({2'b10, 9'h03C});
    send_frame(1'b0, 9'h03C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, -1, 1'b1);
    b0 = brk_cnt;
    exp8_q.push_back({2'b01, 9'h03C});
    send_frame(1'b0, 9'h03C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, -1, 1'b1);
    cyc(BIT_CLKS);
    check("stop_low_no_break", 32'(brk_cnt), 32'(b0));
    drain8("err_drain");

    // Break: all zero with low stop, line held low afterwards.
    b0 = brk_cnt;
    exp8_q.push_back({2'b01, 9'h000});
    send_frame(1'b0, 9'h000, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0);
    line(1'b0, 1'b0, 4*BIT_CLKS);
    check("break_pulse", 32'(brk_cnt), 32'(b0 + 1));
    check("break_no_new_frame", 32'(fifo_count), 32'd0);
    line(1'b0, 1'b1, 2*BIT_CLKS);
    check("break_queue_empty", 32'(exp8_q.size()), 32'd0);

    // Start glitch of 4 ticks: nothing written.
    line(1'b0, 1'b0, 4*DIV);
    line(1'b0, 1'b1, 4*BIT_CLKS);
    check("glitch_start_count", 32'(fifo_count), 32'd0);

    // One-tick glitch in data bit 3 of 0xFF is voted out.
    exp8_q.push_back({2'b00, 9'h0FF});
    send_frame(1'b0, 9'h0FF, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 3, 1'b1);
    drain8("glitch_data_drain");

    // 17 frames into a 16-deep FIFO without reading: last one dropped.
    rd8.rd_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp8_q.push_back({2'b00, 9'(8'h40 + 8'(i))});
      send_frame(1'b0, 9'(8'h40 + 8'(i)), 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
    end
    check("ovr_count_full", 32'(fifo_count), 32'd16);
    check("ovr_set", 32'(overrun), 32'd1);
    rd8.rd_ready = 1'b1;
    drain8("ovr_drain");
    check("ovr_count_empty", 32'(fifo_count), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Full FIFO with a read on frame 17's commit cycle: frame accepted.
    rd8.rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp8_q.push_back({2'b00, 9'(8'h80 + 8'(i))});
      send_frame(1'b0, 9'(8'h80 + 8'(i)), 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
    end
    exp8_q.push_back({2'b00, 9'h0C3});
    fork
      send_frame(1'b0, 9'h0C3, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
      begin
        wait_commit("full_rw_commit_timeout");
        rd8.rd_ready = 1'b1;
        cyc(1);
        rd8.rd_ready = 1'b0;
      end
    join
    check("full_rw_count", 32'(fifo_count), 32'd16);
    check("full_rw_no_overrun", 32'(overrun), 32'd0);
    rd8.rd_ready = 1'b1;
    drain8("full_rw_drain");

    // 9-bit, odd parity, two stop bits.
    exp9_q.push_back({2'b00, 9'h1AB});
    send_frame(1'b1, 9'h1AB, 9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, -1, 1'b1);
    exp9_q.push_back({2'b01, 9'h1AB});
    send_frame(1'b1, 9'h1AB, 9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, -1, 1'b1);
    cyc(2*BIT_CLKS);
    check("fmt9_queue_empty", 32'(exp9_q.size()), 32'd0);

    // Reset during data bit 4 clears everything, including a held entry.
    rd8.rd_ready = 1'b0;
    send_frame(1'b0, 9'h011, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
    check("pre_rst_count", 32'(fifo_count), 32'd1);
    fork
      send_frame(1'b0, 9'h055, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
      begin
        cyc(5*BIT_CLKS + BIT_CLKS/2);
        rst = 1'b1;
      end
    join
    check("midrst_rd_valid", 32'(rd8.rd_valid), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_break", 32'(break_det), 32'd0);
    rst = 1'b0;
    rd8.rd_ready = 1'b1;
    cyc(BIT_CLKS);
    exp8_q.push_back({2'b00, 9'h055});
    send_frame(1'b0, 9'h055, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1'b1);
    drain8("post_rst_drain");

    cyc(BIT_CLKS);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver with majority-vote bit sampling, runtime-configurable frame format and an integrated receive FIFO. Successor to the single-byte receive path inside uart_top: adds configurable data width, per-entry error tagging, overrun and break detection, and a valid/ready read interface. Sits between the synchronised pad input rx and the host/register-bus read logic.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first
OVERSAMPLE, 16, sample ticks per bit; even, minimum 8
FIFO_DEPTH, 16, receive FIFO entries; power of two, minimum 2
DIV_W, 16, width of baud_divisor

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
baud_divisor  in  DIV_W  clk cycles per oversample tick; 0 is treated as 1
stop_bits  in  2  1 or 2 stop bits; 0 and 3 are treated as 1
parity_en  in  1  parity bit present after the data bits
parity_odd  in  1  1 = odd parity, 0 = even parity
rx  in  1  serial input, asynchronous to clk
clr_overrun  in  1  single-cycle clear of overrun
rd_data  out  DATA_BITS  head-of-FIFO data
rd_parity_err  out  1  parity error flag of the head entry
rd_frame_err  out  1  framing error flag of the head entry
rd_valid  out  1  FIFO not empty
rd_ready  in  1  consumer accepts the head entry
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries held
overrun  out  1  sticky flag: a frame was dropped because the FIFO was full
break_det  out  1  one-cycle pulse when a break frame is detected

Behaviour:
- Reset values: rd_valid=0, fifo_count=0, overrun=0, break_det=0. rd_data and the rd_*_err flags are 0 while the FIFO is empty.
- Reset state: FSM=IDLE, synchroniser flops=1, tick counter=0. Reset mid-frame discards the partial frame.
- Input synchronisation: rx passes through a 2-flop synchroniser that resets to 1. All sampling uses the synchronised value.
- Tick generator: free-running counter from 0 to max(baud_divisor,1)-1. Emits a one-cycle tick when it wraps.
- Configuration latch: stop_bits, parity_en and parity_odd are latched on the IDLE->START transition. Changes during a frame do not affect that frame. baud_divisor is used live.
- Sample counter sc runs 0..OVERSAMPLE-1 per bit and advances only on ticks. Bit value = majority of the samples at sc = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM states and transitions:
  - IDLE: on a tick with rx_sync=0, go to START and set sc=0.
  - START: if the start-bit vote is 1 (false start), return to IDLE and write nothing. Otherwise, at sc=OVERSAMPLE-1 go to DATA.
  - DATA: shift in DATA_BITS voted bits, LSB first. After the last bit go to PARITY if parity_en, else to STOP.
  - PARITY: expected value = XOR(data) ^ parity_odd. A mismatch sets parity_err for the frame. Then go to STOP.
  - STOP: vote each stop bit; any stop bit voting 0 sets frame_err. The frame commits on the tick of the last stop bit's final vote sample (mid-bit), then FSM goes to IDLE. The next start edge can therefore be caught within half a bit.
- Break: on commit, if all data bits, the parity bit (when enabled) and the first stop bit are 0, pulse break_det for 1 cycle. The entry is still written, with frame_err=1. The FSM then waits in IDLE for rx_sync=1 before it can accept a new start bit.
- FIFO write at commit:
  - Not full: write {parity_err, frame_err, data}.
  - Full with no read in the same cycle: drop the frame and set overrun.
  - Full with a read in the same cycle: accept the write; count is unchanged.
- FIFO read: a transfer occurs when rd_valid && rd_ready. rd_data and the flags show the head entry combinationally from the registered pointer (first-word fall-through).
- Latency: a commit in cycle N gives rd_valid=1 and the updated fifo_count in cycle N+1. There is no bypass when the FIFO is empty.
- Simultaneous read and write: count is unchanged and both pointers advance. Pointers wrap modulo FIFO_DEPTH; count saturates at FIFO_DEPTH.
- overrun: cleared by clr_overrun. If set and clear occur in the same cycle, set wins.

Test Plan:
- Basic frame: DATA_BITS=8, baud_divisor=2 (32 clk/bit), parity_en=1 even, stop_bits=1; drive 0xA5 -> entry 0xA5 with both error flags 0; rd_valid rises exactly 1 cycle after commit; fifo_count=1.
- Error tagging: 0x3C with a wrong parity bit -> rd_parity_err=1. 0x3C with stop bit=0 -> rd_frame_err=1, break_det stays 0. All-zero frame with low stop -> break_det pulses 1 cycle; no new frame is accepted until rx returns to 1.
- Robustness: a start glitch 4 ticks wide -> no entry written. A single-tick glitch at mid-sample of data bit 3 of 0xFF -> 0xFF still received via majority vote.
- Overrun and full-FIFO cases: 17 frames with rd_ready=0 -> fifo_count=16 and overrun=1; entry 17 is dropped; the first 16 read back in order. Repeat with rd_ready pulsed on the commit cycle of frame 17 -> frame 17 accepted and overrun stays 0.
- Format options: stop_bits=2, parity_odd=1, DATA_BITS=9 build; drive 0x1AB -> correct data with no errors. A second stop bit of 0 -> frame_err=1.
- Reset mid-frame: assert rst during DATA bit 4 -> all outputs at reset values; the next complete frame 0x55 is received correctly.
